// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with double-buffered
// display data, leading-zero blanking and a frame-boundary pulse.
module seg_scan_ctrl #(
  parameter int unsigned DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data,
  input  logic        lz_blank,
  output logic        ready,
  output logic [3:0]  dig_code,
  output logic [3:0]  dig_en,
  output logic        frame_done
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [15:0] PRESC_MAX = 16'(DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] active_q, active_d;
  logic [15:0] pending_q, pending_d;
  logic        pvld_q, pvld_d;
  logic        wrap_seen_q, wrap_seen_d;
  logic [3:0]  dig_en_q, dig_en_d;
  logic [3:0]  dig_code_q, dig_code_d;
  logic        frame_done_q, frame_done_d;

  logic        scanning, slot_end, wrap, blank;
  logic [15:0] upper;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pvld_q       <= 1'b0;
      wrap_seen_q  <= 1'b0;
      dig_en_q     <= '0;
      dig_code_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pvld_q       <= pvld_d;
      wrap_seen_q  <= wrap_seen_d;
      dig_en_q     <= dig_en_d;
      dig_code_q   <= dig_code_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = en ? SCAN : IDLE;
    presc_d      = '0;
    idx_d        = '0;
    active_d     = active_q;
    pending_d    = pending_q;
    pvld_d       = pvld_q;
    wrap_seen_d  = 1'b0;
    dig_en_d     = '0;
    dig_code_d   = '0;
    frame_done_d = 1'b0;

    // Dropping en inside SCAN darkens the display on the very next edge.
    scanning = (state_q == SCAN) && en;
    slot_end = scanning && (presc_q == PRESC_MAX);
    wrap     = slot_end && (idx_q == 2'd3);
    upper    = active_q >> {idx_q, 2'b00};
    blank    = lz_blank && (idx_q != 2'd0) && (upper == 16'd0);

    if (scanning) begin
      presc_d      = slot_end ? 16'd0 : presc_q + 16'd1;
      idx_d        = slot_end ? idx_q + 2'd1 : idx_q;
      wrap_seen_d  = wrap_seen_q | wrap;
      dig_code_d   = upper[3:0];
      dig_en_d     = blank ? 4'b0000 : (4'b0001 << idx_q);
      frame_done_d = wrap_seen_q && (idx_q == 2'd0) && (presc_q == 16'd0);
    end

    // Frame-atomic update: swap only at the 3->0 wrap while scanning.
    if (pvld_q && ((state_q == IDLE) || wrap)) begin
      active_d = pending_q;
      pvld_d   = 1'b0;
    end

    if (load && !pvld_q) begin
      pending_d = data;
      pvld_d    = 1'b1;
    end
  end

  assign ready      = ~pvld_q;
  assign dig_en     = dig_en_q;
  assign dig_code   = dig_code_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised bench for seg_scan_ctrl against a slot-arithmetic reference model.
module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] data;
  logic        lz_blank;
  logic        ready;
  logic [3:0]  dig_code;
  logic [3:0]  dig_en;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  // reference model: cycles since scanning began, and the two data buffers
  bit          m_scan;
  int          m_cnt;
  logic [15:0] m_act, m_pend;
  bit          m_pvld;

  seg_scan_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data),
    .lz_blank(lz_blank), .ready(ready), .dig_code(dig_code),
    .dig_en(dig_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scan = 0; m_cnt = 0; m_act = '0; m_pend = '0; m_pvld = 0;
  endtask

  // One clock: predict from the current inputs, step, then compare.
  task automatic tick();
    int          k, d;
    logic [15:0] up;
    logic [3:0]  e_en, e_code;
    logic        e_fd;
    bit          pv_old;
    e_en = '0; e_code = '0; e_fd = 1'b0;
    k = m_cnt;
    d = (k / DIV) % 4;
    if (m_scan && en) begin
      up     = m_act >> (4 * d);
      e_code = up[3:0];
      e_en   = (lz_blank && d > 0 && up == 16'd0) ? 4'b0000 : (4'b0001 << d);
      e_fd   = (k > 0) && (k % FRAME == 0);
    end
    pv_old = m_pvld;
    if (m_pvld && (!m_scan || (en && k % FRAME == FRAME - 1))) begin
      m_act  = m_pend;
      m_pvld = 0;
    end
    if (load && !pv_old) begin
      m_pend = data;
      m_pvld = 1;
    end
    m_cnt  = (m_scan && en) ? m_cnt + 1 : 0;
    m_scan = en;
    @(posedge clk);
    #1;
    chk("dig_en", 32'(dig_en), 32'(e_en));
    chk("dig_code", 32'(dig_code), 32'(e_code));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("ready", 32'(ready), 32'(!m_pvld));
    chk("onehot", 32'($countones(dig_en) <= 1), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; data = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; data = '0; lz_blank = 1'b0;
    model_reset();
    #12;
    chk("rst_dig_en", 32'(dig_en), 32'd0);
    chk("rst_code", 32'(dig_code), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    rst = 1'b0;
    run(2);

    // IDLE load: ready low for exactly one cycle, then scan 1234
    do_load(16'h1234);
    chk("idle_ready_lo", 32'(ready), 32'd0);
    tick();
    chk("idle_ready_hi", 32'(ready), 32'd1);
    en = 1'b1;
    tick();
    tick();
    chk("first_en", 32'(dig_en), 32'h1);
    chk("first_code", 32'(dig_code), 32'h4);
    run(2 * FRAME + 5);

    // mid-frame load, then a second load that must be ignored
    do_load(16'hABCD);
    do_load(16'h5555);
    run(2 * FRAME + 3);

    // leading-zero blanking
    lz_blank = 1'b1;
    do_load(16'h0070);
    run(2 * FRAME + 2);
    do_load(16'h0000);
    run(2 * FRAME + 2);
    lz_blank = 1'b0;

    // async reset mid-slot with a load pending
    do_load(16'h9876);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_dig_en", 32'(dig_en), 32'd0);
    chk("arst_code", 32'(dig_code), 32'd0);
    chk("arst_fd", 32'(frame_done), 32'd0);
    chk("arst_ready", 32'(ready), 32'd1);
    #1 rst = 1'b0;
    en = 1'b1;
    run(FRAME + 2);

    // drop en during the digit-2 slot, then re-enable
    for (int g = 0; g < 2 * FRAME && (m_cnt % FRAME) != 2 * DIV + 1; g++) tick();
    en = 1'b0;
    tick();
    chk("drop_dark", 32'(dig_en), 32'd0);
    tick();
    en = 1'b1;
    run(DIV + FRAME + 2);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) en = ~en;
      if ($urandom_range(29) == 0) lz_blank = ~lz_blank;
      load = ($urandom_range(7) == 0);
      data = ($urandom_range(3) == 0) ? 16'($urandom_range(255)) : 16'($urandom);
      tick();
    end
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
